// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready on both sides. Logic ops and ADD finish in one
// cycle, shifts take one cycle per bit, MUL is a WIDTH-cycle shift-add.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       FS,
    input  logic             C0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F,
    output logic [3:0]       status
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_e;
    typedef enum logic [2:0] {
        OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_MUL
    } op_e;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [SHW:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]   f_q, f_d;
    logic [3:0]         status_q, status_d;

    op_e                op_in;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   a_c, b_c, quick_f;
    logic               quick_c, quick_v;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   shift_res;
    logic               shift_out;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    function automatic logic [3:0] flags(input logic [WIDTH-1:0] f, input logic c, input logic v);
        return {v, c, f[WIDTH-1], f == '0};
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_AND;
            acc_q    <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            f_q      <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            cnt_q    <= cnt_d;
            f_q      <= f_d;
            status_q <= status_d;
        end
    end

    // Single-cycle datapath on the live inputs; only used at the accept edge.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        op_in   = op_e'(FS[4:2]);
        shamt   = B[SHW-1:0];
        a_c     = FS[1] ? ~A : A;
        b_c     = FS[0] ? ~B : B;
        sum     = {1'b0, a_c} + {1'b0, b_c} + {{WIDTH{1'b0}}, C0};
        quick_f = '0;
        quick_c = 1'b0;
        quick_v = 1'b0;
        case (op_in)
            OP_AND: quick_f = a_c & b_c;
            OP_OR:  quick_f = a_c | b_c;
            OP_XOR: quick_f = a_c ^ b_c;
            OP_ADD: begin
                quick_f = sum[WIDTH-1:0];
                quick_c = sum[WIDTH];
                quick_v = (a_c[WIDTH-1] == b_c[WIDTH-1]) && (sum[WIDTH-1] != a_c[WIDTH-1]);
            end
            default: ;
        endcase
    end

    // One step of the iterative shifter and multiplier. SRA keeps the MSB, which is the captured sign.
    always_comb begin
        shift_res = '0;
        shift_out = 1'b0;
        case (op_q)
            OP_SLL: begin
                shift_res = {acc_q[WIDTH-2:0], 1'b0};
                shift_out = acc_q[WIDTH-1];
            end
            OP_SRL: begin
                shift_res = {1'b0, acc_q[WIDTH-1:1]};
                shift_out = acc_q[0];
            end
            OP_SRA: begin
                shift_res = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
                shift_out = acc_q[0];
            end
            default: ;
        endcase
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        f_d      = f_q;
        status_d = status_q;
        case (state_q)
            S_IDLE: if (in_valid && in_ready) begin
                op_d = op_in;
                case (op_in)
                    OP_SLL, OP_SRL, OP_SRA: begin
                        if (shamt == '0) begin
                            f_d      = A;
                            status_d = flags(A, 1'b0, 1'b0);
                            state_d  = S_DONE;
                        end else begin
                            acc_d   = {{WIDTH{1'b0}}, A};
                            cnt_d   = {1'b0, shamt};
                            state_d = S_SHIFT;
                        end
                    end
                    OP_MUL: begin
                        acc_d   = {{WIDTH{1'b0}}, b_c};
                        mcand_d = a_c;
                        cnt_d   = (SHW+1)'(WIDTH);
                        state_d = S_MUL;
                    end
                    default: begin
                        f_d      = quick_f;
                        status_d = flags(quick_f, quick_c, quick_v);
                        state_d  = S_DONE;
                    end
                endcase
            end
            S_SHIFT: begin
                acc_d[WIDTH-1:0] = shift_res;
                cnt_d            = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    f_d      = shift_res;
                    status_d = flags(shift_res, shift_out, 1'b0);
                    state_d  = S_DONE;
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    f_d      = mul_next[WIDTH-1:0];
                    status_d = flags(mul_next[WIDTH-1:0], 1'b0, |mul_next[2*WIDTH-1:WIDTH]);
                    state_d  = S_DONE;
                end
            end
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = reset_n && (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        F         = f_q;
        status    = status_q;
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32): results, flags, latency, backpressure and reset.
module tb_alu_seq;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [4:0]  FS = '0;
    logic        C0 = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] F;
    logic [3:0]  status;

    int checks = 0;
    int passed = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .FS(FS), .C0(C0), .out_valid(out_valid), .out_ready(out_ready),
        .F(F), .status(status)
    );

    always #5 clock = ~clock;

    // Issue one op, scramble inputs after the accept edge, wait (bounded) for the result, then take it.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] fs,
                          input logic c0, output int lat, output logic [31:0] f, output logic [3:0] st);
        @(negedge clock);
        A = a; B = b; FS = fs; C0 = c0; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0; A = ~a; B = ~b; FS = ~fs; C0 = ~c0;
        lat = 0;
        while (lat < 100) begin
            @(negedge clock);
            lat++;
            if (out_valid) break;
        end
        f = F; st = status;
        out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] fs, input logic c0, input logic [31:0] exp_f,
                            input logic [3:0] exp_st, input int exp_lat);
        int lat;
        logic [31:0] f;
        logic [3:0] st;
        run_op(a, b, fs, c0, lat, f, st);
        checks++;
        if (f !== exp_f || st !== exp_st || lat !== exp_lat)
            $display("FAIL %s: F=%h status=%b lat=%0d, expected F=%h status=%b lat=%0d",
                     name, f, st, lat, exp_f, exp_st, exp_lat);
        else passed++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (F !== 32'h0 || status !== 4'h0 || out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL reset_hold: F=%h status=%b out_valid=%b in_ready=%b, expected all 0",
                     F, status, out_valid, in_ready);
        else passed++;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_release: in_ready=%b, expected 1", in_ready);
        else passed++;
    endtask

    task automatic test_logic();
        check_op("and_invb", 32'hF0F0F0F0, 32'h0FF00FF0, 5'b00001, 1'b0, 32'hF000F000, 4'b0010, 1);
        check_op("or_inva",  32'hFFFF0000, 32'h00000001, 5'b00110, 1'b0, 32'h0000FFFF, 4'b0000, 1);
        check_op("xor_zero", 32'hAAAA5555, 32'hAAAA5555, 5'b01100, 1'b0, 32'h00000000, 4'b0001, 1);
    endtask

    task automatic test_add();
        check_op("add_ovf",  32'h7FFFFFFF, 32'h00000001, 5'b01000, 1'b0, 32'h80000000, 4'b1010, 1);
        check_op("sub_eq",   32'h00000005, 32'h00000005, 5'b01001, 1'b1, 32'h00000000, 4'b0101, 1);
        check_op("add_cin",  32'h00000010, 32'h00000020, 5'b01000, 1'b1, 32'h00000031, 4'b0000, 1);
    endtask

    task automatic test_shift();
        check_op("sra_4",    32'h80000001, 32'h00000004, 5'b11000, 1'b0, 32'hF8000000, 4'b0010, 5);
        check_op("sll_0",    32'h00001234, 32'h00000000, 5'b10000, 1'b0, 32'h00001234, 4'b0000, 1);
        check_op("sll_1",    32'h80000001, 32'h00000001, 5'b10000, 1'b0, 32'h00000002, 4'b0100, 2);
        check_op("srl_31",   32'h80000000, 32'h0000001F, 5'b10100, 1'b0, 32'h00000001, 4'b0000, 32);
        check_op("srl_hib",  32'h00000003, 32'h00000021, 5'b10100, 1'b0, 32'h00000001, 4'b0100, 2);
    endtask

    task automatic test_mul();
        check_op("mul_ovf",  32'h00010000, 32'h00010000, 5'b11100, 1'b0, 32'h00000000, 4'b1001, 33);
        check_op("mul_3x7",  32'h00000003, 32'h00000007, 5'b11100, 1'b0, 32'h00000015, 4'b0000, 33);
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clock);
        A = 32'd1; B = 32'd2; FS = 5'b01000; C0 = 1'b0; in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(negedge clock);
            lat++;
            if (out_valid) break;
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; A = 32'hDEAD0000 + i; FS = 5'b00100;
            @(posedge clock);
            #1 in_valid = 1'b0;
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b1 || F !== 32'd3 || status !== 4'b0000 || in_ready !== 1'b0)
                $display("FAIL hold_%0d: out_valid=%b F=%h status=%b in_ready=%b, expected 1/00000003/0000/0",
                         i, out_valid, F, status, in_ready);
            else passed++;
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL hold_release: out_valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_reset_mid_mul();
        int seen;
        @(negedge clock);
        A = 32'd3; B = 32'd7; FS = 5'b11100; C0 = 1'b0; in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clock);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL mul_busy: in_ready=%b out_valid=%b, expected 0/0", in_ready, out_valid);
        else passed++;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (F !== 32'h0 || status !== 4'h0 || out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL mid_reset: F=%h status=%b out_valid=%b in_ready=%b, expected all 0",
                     F, status, out_valid, in_ready);
        else passed++;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL mid_reset_idle: in_ready=%b, expected 1", in_ready);
        else passed++;
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) $display("FAIL aborted_mul: out_valid high %0d cycles, expected 0", seen);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_logic();
        test_add();
        test_shift();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
